// File: rtl/drive_pkg.sv
// drive_pkg: shared state encoding, field widths and drive-count clamp for the SD arbiter.
package drive_pkg;
    localparam int LBA_W = 32;
    localparam int BLK_W = 6;
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
    function automatic int ndr_clamp(input int d);
        return (d < 1) ? 1 : (d > 4) ? 4 : d;
    endfunction
endpackage

// File: rtl/drive_sd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-set finder starting at rr with wrap.
module rr_pick #(
    parameter int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr,
    output logic [W-1:0] idx,
    output logic         valid
);
    logic [W-1:0] j;
    always_comb begin
        idx   = '0;
        j     = '0;
        valid = |req;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(rr) + k) % N);
            if (req[j]) idx = j;
        end
    end
endmodule

// File: rtl/drive_sd_arbiter.sv
// drive_sd_arbiter: round-robin merge of per-drive SD block requests onto one host SD port with ack watchdog.
module drive_sd_arbiter
    import drive_pkg::*;
#(
    parameter int          DRIVES  = 2,
    parameter logic [23:0] TIMEOUT = 24'd12000000,
    localparam int NDR = ndr_clamp(DRIVES),
    localparam int IW  = (NDR > 1) ? $clog2(NDR) : 1
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [32*NDR-1:0]      drv_lba,
    input  logic [6*NDR-1:0]       drv_blk_cnt,
    input  logic [NDR-1:0]         drv_rd,
    input  logic [NDR-1:0]         drv_wr,
    output logic [NDR-1:0]         drv_ack,
    input  logic [8*NDR-1:0]       drv_buff_din,
    output logic [NDR-1:0]         drv_timeout,
    output logic [LBA_W-1:0]       sd_lba,
    output logic [BLK_W-1:0]       sd_blk_cnt,
    output logic                   sd_rd,
    output logic                   sd_wr,
    input  logic                   sd_ack,
    output logic [7:0]             sd_buff_din,
    output logic                   busy
);
    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d, g_q, g_d, pick_idx;
    logic [23:0]       timer_q, timer_d;
    logic [LBA_W-1:0]  lba_q, lba_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              rd_q, rd_d, wr_q, wr_d, ack_prev_q;
    logic [NDR-1:0]    req;
    logic              pick_valid, ack_rise, tmo_hit, pass;

    assign req      = drv_rd | drv_wr;
    assign ack_rise = sd_ack & ~ack_prev_q;
    assign tmo_hit  = timer_q == TIMEOUT - 24'd1;

    rr_pick #(.N(NDR)) u_pick (.req(req), .rr(rr_q), .idx(pick_idx), .valid(pick_valid));

    // pass covers the ack-rise cycle in REQ so the drive sees every cycle of host ack
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        g_d         = g_q;
        lba_d       = lba_q;
        blk_d       = blk_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        timer_d     = (&timer_q) ? timer_q : timer_q + 24'd1;
        pass        = 1'b0;
        drv_timeout = '0;
        drv_ack     = '0;
        case (state_q)
            IDLE: if (pick_valid) begin
                state_d = REQ;
                g_d     = pick_idx;
                lba_d   = drv_lba[LBA_W*pick_idx +: LBA_W];
                blk_d   = drv_blk_cnt[BLK_W*pick_idx +: BLK_W];
                rd_d    = drv_rd[pick_idx];
                wr_d    = ~drv_rd[pick_idx];
                timer_d = '0;
            end
            REQ: if (ack_rise) begin
                state_d = XFER;
                {rd_d, wr_d} = 2'b00;
                timer_d = '0;
                pass    = 1'b1;
            end else if (tmo_hit) begin
                state_d = DONE;
                {rd_d, wr_d} = 2'b00;
                timer_d = '0;
                drv_timeout[g_q] = 1'b1;
            end
            XFER: begin
                pass = 1'b1;
                if (!sd_ack) begin
                    state_d = DONE;
                    timer_d = '0;
                end
            end
            DONE: begin
                rr_d = (int'(g_q) == NDR - 1) ? '0 : g_q + 1'b1;
                if (!req[g_q] || tmo_hit) begin
                    state_d = IDLE;
                    timer_d = '0;
                    drv_timeout[g_q] = req[g_q];
                end
            end
            default: state_d = IDLE;
        endcase
        drv_ack[g_q] = pass & sd_ack;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            g_q        <= '0;
            timer_q    <= '0;
            lba_q      <= '0;
            blk_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            g_q        <= g_d;
            timer_q    <= timer_d;
            lba_q      <= lba_d;
            blk_q      <= blk_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ack_prev_q <= sd_ack;
        end
    end

    assign sd_lba      = lba_q;
    assign sd_blk_cnt  = blk_q;
    assign sd_rd       = rd_q;
    assign sd_wr       = wr_q;
    assign sd_buff_din = pass ? drv_buff_din[8*g_q +: 8] : 8'h00;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_drive_sd_arbiter.sv
// tb_drive_sd_arbiter: directed self-checking bench for drive_sd_arbiter (2 drives, TIMEOUT 16).
module tb_drive_sd_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [63:0] drv_lba;
    logic [11:0] drv_blk_cnt;
    logic [1:0]  drv_rd, drv_wr, drv_ack, drv_timeout;
    logic [15:0] drv_buff_din;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd, sd_wr, sd_ack, busy;
    logic [7:0]  sd_buff_din;
    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    drive_sd_arbiter #(.DRIVES(2), .TIMEOUT(24'd16)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .drv_lba(drv_lba), .drv_blk_cnt(drv_blk_cnt),
        .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_ack(drv_ack), .drv_buff_din(drv_buff_din),
        .drv_timeout(drv_timeout), .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_din(sd_buff_din), .busy(busy)
    );

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drv_rd = 2'b11;
        repeat (3) step();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if ({sd_rd, sd_wr} !== 2'b00) begin errors++; $display("FAIL rst_strobe got %b exp 00", {sd_rd, sd_wr}); end
        checks++; if (drv_ack !== 2'b00) begin errors++; $display("FAIL rst_ack got %b exp 00", drv_ack); end
        checks++; if (sd_lba !== 32'h0) begin errors++; $display("FAIL rst_lba got %h exp 0", sd_lba); end
        checks++; if (drv_timeout !== 2'b00) begin errors++; $display("FAIL rst_tmo got %b exp 00", drv_timeout); end
        drv_rd = 2'b00;
        reset_n = 1'b1;
        step();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_single_read();
        int bad = 0;
        drv_lba = {32'h0000_0123, 32'h0000_0999};
        drv_blk_cnt = {6'd7, 6'd3};
        drv_rd = 2'b10;
        step();
        #1;
        checks++; if (sd_rd !== 1'b1) begin errors++; $display("FAIL rd_strobe got %b exp 1", sd_rd); end
        checks++; if (sd_lba !== 32'h123) begin errors++; $display("FAIL rd_lba got %h exp 123", sd_lba); end
        checks++; if (sd_blk_cnt !== 6'd7) begin errors++; $display("FAIL rd_blk got %0d exp 7", sd_blk_cnt); end
        checks++; if (drv_ack !== 2'b00) begin errors++; $display("FAIL rd_ack_early got %b exp 00", drv_ack); end
        drv_lba = {32'hDEAD_BEEF, 32'h0000_0999};
        for (int i = 0; i < 512; i++) begin
            sd_ack = 1'b1;
            #1;
            if (drv_ack !== 2'b10 || (i > 0 && sd_rd !== 1'b0)) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rd_ack_window got %0d bad cycles exp 0", bad); end
        sd_ack = 1'b0;
        #1;
        checks++; if (drv_ack !== 2'b00) begin errors++; $display("FAIL rd_ack_end got %b exp 00", drv_ack); end
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_done_busy got %b exp 1", busy); end
        checks++; if (sd_lba !== 32'h123) begin errors++; $display("FAIL rd_lba_hold got %h exp 123", sd_lba); end
        drv_rd = 2'b00;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_release got %b exp 0", busy); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_ack;
        drv_lba = {32'h0000_00B0, 32'h0000_00A0};
        drv_rd = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_ack = (t % 2 == 0) ? 2'b01 : 2'b10;
            step();
            checks++; if (sd_lba !== ((t % 2 == 0) ? 32'hA0 : 32'hB0)) begin errors++; $display("FAIL cont_grant%0d got %h", t, sd_lba); end
            sd_ack = 1'b1;
            #1;
            checks++; if (drv_ack !== exp_ack) begin errors++; $display("FAIL cont_ack%0d got %b exp %b", t, drv_ack, exp_ack); end
            step();
            sd_ack = 1'b0;
            step();
            drv_rd = ~exp_ack;
            step();
            drv_rd = 2'b11;
        end
        drv_rd = 2'b00;
        step();
    endtask

    task automatic test_write();
        drv_wr = 2'b01;
        drv_buff_din = {8'h5A, 8'hA5};
        step();
        checks++; if ({sd_rd, sd_wr} !== 2'b01) begin errors++; $display("FAIL wr_strobe got %b exp 01", {sd_rd, sd_wr}); end
        sd_ack = 1'b1;
        #1;
        checks++; if (sd_buff_din !== 8'hA5) begin errors++; $display("FAIL wr_din0 got %h exp a5", sd_buff_din); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (sd_buff_din !== 8'hA5 || drv_ack !== 2'b01 || sd_wr !== 1'b0) begin
                errors++; $display("FAIL wr_xfer%0d got din %h ack %b wr %b exp a5 01 0", i, sd_buff_din, drv_ack, sd_wr);
            end
        end
        sd_ack = 1'b0;
        step();
        drv_wr = 2'b00;
        step();
    endtask

    task automatic test_timeout();
        drv_lba = {32'h0000_0B0B, 32'h0000_0A0A};
        drv_rd = 2'b01;
        step();
        drv_rd = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            #1;
            checks++; if (drv_timeout !== ((k == 16) ? 2'b01 : 2'b00) || sd_rd !== 1'b1) begin
                errors++; $display("FAIL tmo_cycle%0d got tmo %b rd %b", k, drv_timeout, sd_rd);
            end
            step();
        end
        checks++; if (sd_rd !== 1'b0 || drv_timeout !== 2'b00) begin errors++; $display("FAIL tmo_drop got rd %b tmo %b exp 0 00", sd_rd, drv_timeout); end
        drv_rd = 2'b10;
        step();
        step();
        checks++; if (sd_lba !== 32'hB0B || sd_rd !== 1'b1) begin errors++; $display("FAIL tmo_next got lba %h rd %b exp b0b 1", sd_lba, sd_rd); end
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        step();
        drv_rd = 2'b00;
        step();
    endtask

    task automatic test_stale_ack();
        sd_ack = 1'b1;
        drv_rd = 2'b01;
        step();
        repeat (3) begin
            #1;
            checks++; if (drv_ack !== 2'b00 || sd_rd !== 1'b1) begin errors++; $display("FAIL stale_hold got ack %b rd %b exp 00 1", drv_ack, sd_rd); end
            step();
        end
        sd_ack = 1'b0;
        step();
        checks++; if (drv_ack !== 2'b00 || sd_rd !== 1'b1) begin errors++; $display("FAIL stale_low got ack %b rd %b exp 00 1", drv_ack, sd_rd); end
        sd_ack = 1'b1;
        #1;
        checks++; if (drv_ack !== 2'b01) begin errors++; $display("FAIL stale_fresh got %b exp 01", drv_ack); end
        step();
        checks++; if (sd_rd !== 1'b0) begin errors++; $display("FAIL stale_xfer_rd got %b exp 0", sd_rd); end
        sd_ack = 1'b0;
        step();
        drv_rd = 2'b00;
        step();
    endtask

    task automatic test_reset_mid_xfer();
        drv_rd = 2'b01;
        step();
        sd_ack = 1'b1;
        step();
        checks++; if (drv_ack !== 2'b01) begin errors++; $display("FAIL mid_xfer got %b exp 01", drv_ack); end
        reset_n = 1'b0;
        drv_rd = 2'b00;
        step();
        #1;
        checks++; if (busy !== 1'b0 || drv_ack !== 2'b00 || sd_rd !== 1'b0 || sd_lba !== 32'h0 || sd_buff_din !== 8'h00) begin
            errors++; $display("FAIL mid_reset got busy %b ack %b rd %b lba %h din %h exp all 0", busy, drv_ack, sd_rd, sd_lba, sd_buff_din);
        end
        reset_n = 1'b1;
        sd_ack = 1'b0;
        drv_rd = 2'b11;
        step();
        step();
        checks++; if (sd_lba !== 32'hA0A || sd_rd !== 1'b1) begin errors++; $display("FAIL post_reset_rr got lba %h rd %b exp a0a 1", sd_lba, sd_rd); end
        drv_rd = 2'b10;
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        step();
        drv_rd = 2'b10;
        step();
        step();
        checks++; if (sd_lba !== 32'hB0B || sd_rd !== 1'b1) begin errors++; $display("FAIL post_reset_d1 got lba %h rd %b exp b0b 1", sd_lba, sd_rd); end
    endtask

    initial begin
        reset_n = 1'b0;
        drv_lba = '0;
        drv_blk_cnt = '0;
        drv_rd = '0;
        drv_wr = '0;
        drv_buff_din = '0;
        sd_ack = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_timeout();
        test_stale_ack();
        test_reset_mid_xfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
